// File: rtl/riscv_fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default queue depth, pointer/count width helpers, queue entry struct.
package riscv_fetch_pkg;

    localparam int FETCH_DEPTH      = 4;
    localparam int FETCH_ADDR_WIDTH = 32;
    localparam int FETCH_DATA_WIDTH = 32;

    // Pointer width: indexes DEPTH entries (power of two, so wrap is free).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: one extra bit so the value DEPTH itself is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Entry fields are sized by the package widths; the fetch stage
    // parameters must not exceed them.
    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0] data;
        logic                        filled;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_stage_fetch_queue.sv
// In-order fetch queue: alloc at tail on request, fill in order on response, pop at head.
// Latency: fill visible at head_filled the cycle after the filling edge.
// Backpressure: none internally; caller gates alloc with credit and pop with head_filled.
// Ports: clk/rst_n, clear, alloc+alloc_pc, fill+fill_data, pop; head_* view, count, unfilled.
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH      = FETCH_DEPTH,
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        alloc,
    input  logic [ADDR_WIDTH-1:0]       alloc_pc,
    input  logic                        fill,
    input  logic [DATA_WIDTH-1:0]       fill_data,
    input  logic                        pop,
    output logic [ADDR_WIDTH-1:0]       head_pc,
    output logic [DATA_WIDTH-1:0]       head_data,
    output logic                        head_filled,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic [cnt_width(DEPTH)-1:0] unfilled
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    fetch_entry_t  entries [DEPTH];
    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] head_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] unfilled_q;
    logic          not_empty;

    assign not_empty   = (count_q != '0);
    assign head_filled = not_empty & entries[head_ptr].filled;
    assign head_pc     = not_empty ? ADDR_WIDTH'(entries[head_ptr].pc)   : '0;
    assign head_data   = not_empty ? DATA_WIDTH'(entries[head_ptr].data) : '0;
    assign count       = count_q;
    assign unfilled    = unfilled_q;

    // alloc, fill and pop always hit different entries: fill only targets
    // allocated-unfilled slots, pop only a filled head, alloc only a free tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
        end else begin
            if (alloc) begin
                entries[alloc_ptr].pc     <= FETCH_ADDR_WIDTH'(alloc_pc);
                entries[alloc_ptr].data   <= '0;
                entries[alloc_ptr].filled <= 1'b0;
                alloc_ptr                 <= alloc_ptr + PW'(1);
            end
            if (fill) begin
                entries[fill_ptr].data   <= FETCH_DATA_WIDTH'(fill_data);
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + PW'(1);
            end
            if (pop) begin
                entries[head_ptr].filled <= 1'b0;
                head_ptr                 <= head_ptr + PW'(1);
            end
            count_q    <= count_q + CW'(alloc) - CW'(pop);
            unfilled_q <= unfilled_q + CW'(alloc) - CW'(fill);
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC -> imem request, in-order responses queued, {instruction, pc} to decode.
// Latency: request combinational from PC; response to INSTRUCTION_VALID one cycle.
// Backpressure: PC_READY drops when queued + squashed-in-flight reaches DEPTH; decode stalls hold head.
// Ports: PC/PC_VALID/PC_READY in, IMEM_REQ_* out, IMEM_RESP_* in, CLEAR, STALL_DECODING_STAGE, INSTRUCTION* out.
module instruction_fetch_stage
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH      = FETCH_DEPTH,
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic                  PC_VALID,
    output logic                  PC_READY,
    output logic                  IMEM_REQ_VALID,
    output logic [ADDR_WIDTH-1:0] IMEM_REQ_ADDR,
    input  logic                  IMEM_REQ_READY,
    input  logic                  IMEM_RESP_VALID,
    input  logic [DATA_WIDTH-1:0] IMEM_RESP_DATA,
    input  logic                  CLEAR,
    input  logic                  STALL_DECODING_STAGE,
    output logic [DATA_WIDTH-1:0] INSTRUCTION,
    output logic [ADDR_WIDTH-1:0] PC_FETCHED,
    output logic                  INSTRUCTION_VALID
);

    localparam int CW = cnt_width(DEPTH);

    logic [CW-1:0] count;
    logic [CW-1:0] unfilled;
    logic [CW-1:0] drop;
    logic          credit;
    logic          resp_drop;
    logic          resp_fill;
    logic          head_filled;
    logic          pop;

    // Squashed responses still occupy memory slots, so they consume credit
    // until they come back; this caps outstanding requests at DEPTH.
    assign credit = ({1'b0, count} + {1'b0, drop}) < (CW+1)'(DEPTH);

    assign IMEM_REQ_VALID = PC_VALID & credit & ~CLEAR;
    assign IMEM_REQ_ADDR  = PC;
    assign PC_READY       = IMEM_REQ_VALID & IMEM_REQ_READY;

    // Squashed responses are owed first; a response with nothing owed and
    // nothing unfilled is ignored.
    assign resp_drop = IMEM_RESP_VALID & (drop != '0);
    assign resp_fill = IMEM_RESP_VALID & (drop == '0) & (unfilled != '0);

    assign INSTRUCTION_VALID = head_filled & ~CLEAR;
    assign pop               = INSTRUCTION_VALID & ~STALL_DECODING_STAGE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop <= '0;
        end else if (CLEAR) begin
            // Every unfilled entry becomes a squashed response, minus one
            // if a legitimately owed response lands in this very cycle.
            drop <= drop + unfilled - CW'(resp_drop | resp_fill);
        end else if (resp_drop) begin
            drop <= drop - CW'(1);
        end
    end

    fetch_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fetch_queue (
        .clk         (CLK),
        .rst_n       (RST_N),
        .clear       (CLEAR),
        .alloc       (PC_READY),
        .alloc_pc    (PC),
        .fill        (resp_fill),
        .fill_data   (IMEM_RESP_DATA),
        .pop         (pop),
        .head_pc     (PC_FETCHED),
        .head_data   (INSTRUCTION),
        .head_filled (head_filled),
        .count       (count),
        .unfilled    (unfilled)
    );

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Consumer side of the program-counter interface: accepts fetch addresses from the PC stage, issues them to instruction memory over a valid/ready request channel, collects in-order responses and presents {instruction, PC} pairs to the decoding stage. A small tagged queue decouples memory latency from decode stalls. Flushes from a mispredict (clear of the decoding stage) discard queued entries and squash responses still in flight.

## Interface
- DEPTH, 4, fetch queue entries and maximum outstanding memory requests (power of 2, ≥2)
- ADDR_WIDTH, 32, PC / memory address width
- DATA_WIDTH, 32, instruction width
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- PC  in  ADDR_WIDTH  fetch address from PC stage
- PC_VALID  in  1  PC holds a fetch address
- PC_READY  out  1  address accepted this cycle; PC stage advances
- IMEM_REQ_VALID  out  1  memory request valid
- IMEM_REQ_ADDR  out  ADDR_WIDTH  memory request address
- IMEM_REQ_READY  in  1  memory accepts request
- IMEM_RESP_VALID  in  1  response valid (in order, no backpressure)
- IMEM_RESP_DATA  in  DATA_WIDTH  response instruction word
- CLEAR  in  1  flush (driven by CLEAR_DECODING_STAGE)
- STALL_DECODING_STAGE  in  1  decode cannot accept
- INSTRUCTION  out  DATA_WIDTH  head instruction
- PC_FETCHED  out  ADDR_WIDTH  PC of head instruction
- INSTRUCTION_VALID  out  1  head entry filled and deliverable

## Operation
- Queue entry = {pc, data, filled}; pointers: alloc (tail), fill, head; count = allocated-not-popped entries; drop = squashed responses still owed.
- credit = (count + drop < DEPTH).
- IMEM_REQ_VALID = PC_VALID & credit & ~CLEAR; IMEM_REQ_ADDR = PC (combinational pass-through).
- PC_READY = IMEM_REQ_VALID & IMEM_REQ_READY; on handshake allocate entry at tail with pc = PC, filled = 0.
- Response: if drop > 0, decrement drop and discard data; else write data into fill entry, set filled, advance fill. Response with count-unfilled = 0 and drop = 0 is a protocol error: ignored, no state change.
- INSTRUCTION_VALID = head.filled & ~CLEAR; INSTRUCTION / PC_FETCHED = head fields (zero when queue empty).
- Pop when INSTRUCTION_VALID & ~STALL_DECODING_STAGE: advance head, count − 1.
- CLEAR: all entries invalidated, count ← 0, pointers ← 0; drop ← drop + unfilled-allocated − (1 if a response arrives this cycle). No request, no pop in the CLEAR cycle.
- Pointers wrap modulo DEPTH; count and drop are clog2(DEPTH)+1 bits, never exceed DEPTH.
- Simultaneous allocate + pop: count unchanged. Simultaneous allocate + fill of same entry impossible (fill only targets already allocated entries).

## Timing
- Request: zero-cycle, combinational from PC/PC_VALID.
- Response at edge N → INSTRUCTION_VALID high in cycle after edge N (1-cycle min latency memory-to-decode).
- Back-to-back: with single-cycle memory, one instruction per cycle sustained.
- Reset (RST_N low, async): count, drop, pointers, filled bits, stored pc/data ← 0; INSTRUCTION_VALID 0, INSTRUCTION 0, PC_FETCHED 0; IMEM_REQ_VALID follows PC_VALID (full credit). Reset mid-operation abandons outstanding responses; memory is reset by the same RST_N.
- Full: credit = 0 → IMEM_REQ_VALID 0, PC_READY 0 until a pop or a drop decrement.

## Structure
- Shared package riscv_fetch_pkg: DEPTH default, pointer/count width function, entry struct {pc, data, filled}.
- Sub-module fetch_queue: entry storage with alloc/fill/head pointers and count; top level holds drop counter, credit and handshake logic.

## Test plan
- Reset, PC_VALID=1, PC=0x0, memory ready, 1-cycle response 0x00000013 → PC_READY=1 same cycle; INSTRUCTION_VALID=1, INSTRUCTION=0x00000013, PC_FETCHED=0x0 two cycles later.
- Stream PC 0x0,0x4,0x8,0xC with STALL_DECODING_STAGE=1 → exactly 4 handshakes, then PC_READY=0; release stall → deliveries in order 0x0..0xC, one per cycle.
- 3 requests issued with 3-cycle memory latency, CLEAR pulsed before any response → next 3 responses discarded, INSTRUCTION_VALID stays 0; request at PC 0x100 after CLEAR delivered with PC_FETCHED=0x100.
- CLEAR coincident with a response and 2 unfilled entries → drop = 1; exactly one further response discarded.
- Unsolicited IMEM_RESP_VALID with empty queue → no output, counters unchanged.
- RST_N asserted with 2 entries filled → outputs 0 asynchronously, queue empty after release.
